// File: rtl/mvm_stream_driver.sv
// mvm_stream_driver: host-side operand streamer and result collector for the matrix-vector multiplier.
// Optional done-watchdog enabled by defining MVM_DRIVER_WATCHDOG_EN.
module mvm_stream_driver #(
    parameter int DATA_W         = 8,
    parameter int RES_W          = 16,
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_mvm_start,
    output logic [DATA_W-1:0] o_mvm_data_in,
    input  logic              i_mvm_done,
    input  logic [RES_W-1:0]  i_mvm_data_out,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [RES_W-1:0]  o_out_data,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_error
);
    localparam int OPS = N*N + N;
    localparam int CW  = $clog2(OPS);
    localparam int RW  = $clog2(N);
    localparam logic [CW-1:0] LAST_OP = CW'(OPS-1);
    localparam logic [RW-1:0] LAST_R  = RW'(N-1);
    localparam logic [RES_W-1:0] MIN_RES = {1'b1, {(RES_W-1){1'b0}}};
    localparam logic [2:0] S_FILL = 3'd0, S_START = 3'd1, S_STREAM = 3'd2,
                           S_WAIT = 3'd3, S_CAPT = 3'd4, S_DRAIN = 3'd5;
    logic [2:0]        r_state;
    logic [CW-1:0]     r_wcnt, r_scnt;
    logic [RW-1:0]     r_rcnt;
    logic [DATA_W-1:0] r_op_buf [OPS];
    logic [RES_W-1:0]  r_y [N];
    logic              w_in_hs, w_out_hs, w_timeout;
    assign w_in_hs  = i_in_valid && o_in_ready;
    assign w_out_hs = o_out_valid && i_out_ready;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FILL;
            r_wcnt  <= '0;
            r_scnt  <= '0;
            r_rcnt  <= '0;
        end else begin
            case (r_state)
                S_FILL: if (w_in_hs) begin
                    r_wcnt  <= (r_wcnt == LAST_OP) ? '0 : r_wcnt + 1'b1;
                    r_state <= (r_wcnt == LAST_OP) ? S_START : S_FILL;
                end
                S_START: r_state <= S_STREAM;
                S_STREAM: begin
                    r_scnt  <= (r_scnt == LAST_OP) ? '0 : r_scnt + 1'b1;
                    r_state <= (r_scnt == LAST_OP) ? S_WAIT : S_STREAM;
                end
                S_WAIT: if (i_mvm_done) begin
                    r_rcnt  <= RW'(1);
                    r_state <= S_CAPT;
                end else if (w_timeout) begin
                    r_rcnt  <= '0;
                    r_state <= S_DRAIN;
                end
                // results after done arrive back-to-back with no handshake
                S_CAPT: begin
                    r_rcnt  <= (r_rcnt == LAST_R) ? '0 : r_rcnt + 1'b1;
                    r_state <= (r_rcnt == LAST_R) ? S_DRAIN : S_CAPT;
                end
                S_DRAIN: if (w_out_hs) begin
                    r_rcnt  <= (r_rcnt == LAST_R) ? '0 : r_rcnt + 1'b1;
                    r_state <= (r_rcnt == LAST_R) ? S_FILL : S_DRAIN;
                end
                default: r_state <= S_FILL;
            endcase
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_in_hs) r_op_buf[r_wcnt] <= i_in_data;
        if (r_state == S_WAIT && i_mvm_done) r_y[0] <= i_mvm_data_out;
        if (r_state == S_CAPT) r_y[r_rcnt] <= i_mvm_data_out;
        if (w_timeout) for (int i = 0; i < N; i++) r_y[i] <= MIN_RES;
    end
`ifdef MVM_DRIVER_WATCHDOG_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES+1) > 8) ? $clog2(TIMEOUT_CYCLES+1) : 8;
    logic [WD_W-1:0] r_wd;
    logic            r_error;
    assign w_timeout = (r_state == S_WAIT) && !i_mvm_done && (r_wd == WD_W'(TIMEOUT_CYCLES-1));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd    <= '0;
            r_error <= 1'b0;
        end else begin
            r_wd <= (r_state == S_WAIT && !i_mvm_done && !w_timeout) ? r_wd + 1'b1 : '0;
            if (w_timeout) r_error <= 1'b1;
        end
    end
    assign o_error = r_error;
`else
    // watchdog compiled out: WAIT never times out
    assign w_timeout = (TIMEOUT_CYCLES < 0);
    assign o_error   = 1'b0;
`endif
    assign o_in_ready    = r_state == S_FILL;
    assign o_busy        = r_state != S_FILL;
    assign o_mvm_start   = r_state == S_START;
    assign o_mvm_data_in = (r_state == S_START)  ? r_op_buf[0] :
                           (r_state == S_STREAM) ? r_op_buf[r_scnt] : '0;
    assign o_out_valid   = r_state == S_DRAIN;
    assign o_out_data    = (r_state == S_DRAIN) ? r_y[r_rcnt] : '0;
    assign o_out_last    = (r_state == S_DRAIN) && (r_rcnt == LAST_R);
endmodule

// File: doc/mvm_stream_driver.md
Name: mvm_stream_driver

Overview:
- Host-side driver for the matrix-vector multiplier. It is the transmitting end of the multiplier's serial operand port and the receiving end of its serial result port.
- Accepts 20 signed bytes from an upstream valid/ready source: 16 matrix elements in row-major order, then 4 vector elements.
- Issues a one-cycle start to the multiplier and streams the bytes on consecutive cycles.
- Captures the 4 signed 16-bit results that follow done and hands them downstream over valid/ready.

Parameters:
- DATA_W, 8, operand width (signed).
- RES_W, 16, result width (signed).
- N, 4, matrix dimension. Operand count is N*N+N (20); result count is N.
- TIMEOUT_CYCLES, 255, watchdog limit for waiting on done (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  driver can accept an operand.
- in_data  in  DATA_W  signed operand.
- mvm_start  out  1  one-cycle start pulse to the multiplier.
- mvm_data_in  out  DATA_W  serial operand to the multiplier.
- mvm_done  in  1  multiplier result-ready strobe.
- mvm_data_out  in  RES_W  serial result from the multiplier.
- out_valid  out  1  result valid downstream.
- out_ready  in  1  downstream accepts a result.
- out_data  out  RES_W  signed result y[i].
- out_last  out  1  high with y[N-1].
- busy  out  1  high in any state other than FILL.
- error  out  1  sticky watchdog flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to FILL and all counters clear.
  - Outputs: in_ready=1, mvm_start=0, mvm_data_in=0, out_valid=0, out_data=0, out_last=0, busy=0, error=0.
  - Reset mid-operation aborts the transaction. Buffer contents are don't-care; counters clear.
- FILL:
  - in_ready=1. Each in_valid&in_ready handshake writes op_buf[wcnt] and increments wcnt.
  - On the 20th handshake, in_ready drops on the following cycle and the state moves to START.
  - No operand is accepted outside FILL.
- START:
  - mvm_start=1 for exactly one cycle, with mvm_data_in=op_buf[0]. Go to STREAM.
- STREAM:
  - The cycle after mvm_start, mvm_data_in=op_buf[0]. Each later cycle advances one entry, so op_buf[k] is driven k+1 cycles after the start cycle, k=0..19.
  - The stream has no gaps and no backpressure.
  - After op_buf[19], mvm_data_in returns to 0. Go to WAIT.
- WAIT:
  - Hold until mvm_done=1.
  - In the mvm_done cycle, capture mvm_data_out as y[0]. Capture y[1..3] on the next 3 cycles unconditionally, then go to DRAIN.
  - mvm_done asserted during START or STREAM is ignored.
- DRAIN:
  - out_valid=1 and out_data=y[rcnt]; out_last=1 when rcnt=N-1.
  - On out_valid&out_ready, increment rcnt. Holding out_ready low stalls with out_data stable.
  - After the last handshake: out_valid=0, clear counters, state goes to FILL, in_ready=1 the next cycle.
- Arithmetic:
  - No arithmetic on data. Values pass bit-exact, with sign preserved.
  - Counters are ceil(log2) width with no wrap beyond terminal counts: wcnt 0..19, scnt 0..19, rcnt 0..3.
- Latency:
  - Last operand accepted to mvm_start: 1 cycle.
  - Transaction floor: 20 fill + 1 start + 20 stream + multiplier compute + 4 capture + 4 drain cycles.

Optional Feature:
- Macro: MVM_DRIVER_WATCHDOG_EN.
- Defined:
  - An 8-bit-or-wider counter runs in WAIT.
  - If TIMEOUT_CYCLES elapse without mvm_done, error is set (sticky until reset), out_data=16'sh8000 for all 4 results, and the state goes to DRAIN.
- Undefined: no counter is present, WAIT holds indefinitely, and error is tied 0.

Test Plan:
1. Reset then feed operands 1..20 with in_valid held high -> in_ready drops after 20 accepts. mvm_start pulses once, then mvm_data_in=1,2,...,20 on 20 consecutive cycles, then 0.
2. Model returns mvm_done plus results 30,70,110,150 with out_ready=1 -> out_data=30,70,110,150 on consecutive cycles, out_last only with 150, then in_ready=1.
3. Operands -128 and 127 mixed in, results -32768 and 32767 -> exact sign-preserving pass-through on mvm_data_in and out_data.
4. out_ready toggled 1,0,0,1,… during DRAIN -> out_data held stable while stalled, no result lost or duplicated, out_last exactly once.
5. Assert reset low mid-STREAM (operand 7 driven) -> outputs return to reset values immediately. A full new transaction afterwards completes correctly.
6. With MVM_DRIVER_WATCHDOG_EN and TIMEOUT_CYCLES=10, never assert mvm_done -> error=1 after 10 WAIT cycles, 4 outputs of -32768 delivered, error stays high in the next transaction.
